// File: rtl/uart_core_v2.sv
// uart_core_v2 - register-mapped UART with TX/RX FIFOs, 5..8 data bits,
// optional even/odd parity, 1 or 2 stop bits, loopback, sticky errors,
// watermark and RX-timeout interrupts.
// Ports:
//   pclk_i, prst_i             clock, synchronous active-high reset
//   paddr_i, pwdata_i          byte address / write data
//   pwrite_i, pread_i          access strobes (write wins)
//   prdata_o                   registered read data, held until next read
//   rx_i, tx_o                 serial pads (tx_o idle high)
//   intr_*_o                   registered level interrupts
module uart_core_v2 #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int BAUD_W     = 16
) (
   input  logic        pclk_i,
   input  logic        prst_i,
   input  logic [11:0] paddr_i,
   input  logic [31:0] pwdata_i,
   input  logic        pwrite_i,
   input  logic        pread_i,
   output logic [31:0] prdata_o,
   input  logic        rx_i,
   output logic        tx_o,
   output logic        intr_tx_o,
   output logic        intr_rx_o,
   output logic        intr_rx_timeout_o,
   output logic        intr_err_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [BAUD_W:0]   ONE_B = 1;
   localparam logic [BAUD_W-1:0] ONE_N = 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} st_t;

   // configuration and status
   logic [BAUD_W-1:0] baud;
   logic [5:0]        ctrl;
   logic [3:0]        ie;
   logic [7:0]        tx_wm, rx_wm, rx_to;
   logic              rx_ovf, par_err, frm_err, tx_ovf;

   logic rd, wr_tx, wr_st, rd_rx;
   logic unused_bits;
   assign rd          = pread_i & ~pwrite_i;
   assign wr_tx       = pwrite_i && paddr_i == 12'h004;
   assign wr_st       = pwrite_i && paddr_i == 12'h010;
   assign rd_rx       = rd && paddr_i == 12'h008;
   assign unused_bits = ^pwdata_i;

   // FIFOs
   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
   logic [CW-1:0]     tx_cnt, rx_cnt;
   logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;

   // TX
   st_t               tx_st, tx_nx;
   logic [BAUD_W-1:0] t_n;
   logic [BAUD_W:0]   t_cnt, t_lim;
   logic [3:0]        t_bit;
   logic [DATA_W-1:0] t_sh;
   logic t_par_en, t_stop2, t_par, t_last, t_line, tx_q, tx_go, tx_ok;

   // RX
   st_t               rx_st, rx_nx;
   logic [BAUD_W-1:0] r_n, r_cnt;
   logic [3:0]        r_bit;
   logic [DATA_W-1:0] r_sh;
   logic s1, s2, s_prev, r_par_en, r_odd, r_go, r_samp, byte_v;
   logic frm_set, par_set, ovf_set;

   // timeout
   logic [BAUD_W-1:0] to_div;
   logic [7:0]        to_cnt;
   logic              to_flag;

   logic [31:0] status;

   assign tx_full  = tx_cnt == CW'(FIFO_DEPTH);
   assign tx_empty = tx_cnt == '0;
   assign rx_full  = rx_cnt == CW'(FIFO_DEPTH);
   assign rx_empty = rx_cnt == '0;
   assign tx_push  = wr_tx & ~tx_full;
   assign tx_pop   = tx_go;
   assign rx_push  = byte_v & ~rx_full;
   assign rx_pop   = rd_rx & ~rx_empty;
   assign tx_ok    = ctrl[0] & ~tx_empty & (baud >= BAUD_W'(4));
   // loopback keeps the pad quiet while the frame runs internally
   assign tx_o     = tx_q | ctrl[5];

   always_ff @(posedge pclk_i) begin
      if (tx_push) tx_mem[tx_wp] <= pwdata_i[DATA_W-1:0];
      if (rx_push) rx_mem[rx_wp] <= r_sh;
   end

   // TX next state; t_line is the bit level for the current state
   always_comb begin
      tx_nx  = tx_st;
      tx_go  = 1'b0;
      t_line = 1'b1;
      t_lim  = (tx_st == S_STOP && t_stop2) ? {t_n, 1'b0} - ONE_B : {1'b0, t_n} - ONE_B;
      t_last = t_cnt == t_lim;
      case (tx_st)
         S_IDLE:  if (tx_ok) begin tx_nx = S_START; tx_go = 1'b1; end
         S_START: begin t_line = 1'b0; if (t_last) tx_nx = S_DATA; end
         S_DATA:  begin
            t_line = t_sh[0];
            if (t_last && t_bit == 4'(DATA_W-1)) tx_nx = t_par_en ? S_PAR : S_STOP;
         end
         S_PAR:   begin t_line = t_par; if (t_last) tx_nx = S_STOP; end
         S_STOP:  if (t_last) begin
            // back-to-back frames skip IDLE entirely
            if (tx_ok) begin tx_nx = S_START; tx_go = 1'b1; end
            else tx_nx = S_IDLE;
         end
         default: tx_nx = S_IDLE;
      endcase
   end

   // RX next state; START samples mid-bit, later bits N cycles apart
   always_comb begin
      rx_nx   = rx_st;
      r_go    = 1'b0;
      r_samp  = (rx_st == S_START) ? (r_cnt == (r_n >> 1)) : (r_cnt == r_n - ONE_N);
      frm_set = 1'b0;
      par_set = 1'b0;
      case (rx_st)
         S_IDLE:  if (s_prev && !s2 && ctrl[1] && baud >= BAUD_W'(4)) begin
            rx_nx = S_START; r_go = 1'b1;
         end
         S_START: if (r_samp) rx_nx = s2 ? S_IDLE : S_DATA;
         S_DATA:  if (r_samp && r_bit == 4'(DATA_W-1)) rx_nx = r_par_en ? S_PAR : S_STOP;
         S_PAR:   if (r_samp) begin
            rx_nx   = S_STOP;
            par_set = s2 != (^r_sh ^ r_odd);
         end
         S_STOP:  if (r_samp) begin rx_nx = S_IDLE; frm_set = ~s2; end
         default: rx_nx = S_IDLE;
      endcase
      ovf_set = byte_v & rx_full;
   end

   always_comb begin
      status        = '0;
      status[0]     = tx_full;
      status[1]     = tx_empty;
      status[2]     = rx_full;
      status[3]     = rx_empty;
      status[4]     = tx_st != S_IDLE;
      status[5]     = rx_ovf;
      status[6]     = par_err;
      status[7]     = frm_err;
      status[15:8]  = 8'(tx_cnt);
      status[23:16] = 8'(rx_cnt);
      // bit 8 is shared: TX_OVF overlays the LSB of tx_count
      status[8]     = tx_cnt[0] | tx_ovf;
   end

   always_ff @(posedge pclk_i) begin
      if (prst_i) begin
         baud <= '0; ctrl <= '0; ie <= '0; tx_wm <= '0; rx_wm <= '0; rx_to <= '0;
         rx_ovf <= 1'b0; par_err <= 1'b0; frm_err <= 1'b0; tx_ovf <= 1'b0;
         tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0; rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
         tx_st <= S_IDLE; tx_q <= 1'b1; t_n <= '0; t_cnt <= '0; t_bit <= '0; t_sh <= '0;
         t_par_en <= 1'b0; t_stop2 <= 1'b0; t_par <= 1'b0;
         // synchroniser idles high so reset release is not a falling edge
         s1 <= 1'b1; s2 <= 1'b1; s_prev <= 1'b1;
         rx_st <= S_IDLE; r_n <= '0; r_cnt <= '0; r_bit <= '0; r_sh <= '0;
         r_par_en <= 1'b0; r_odd <= 1'b0; byte_v <= 1'b0;
         to_div <= '0; to_cnt <= '0; to_flag <= 1'b0;
         prdata_o <= '0;
         intr_tx_o <= 1'b0; intr_rx_o <= 1'b0; intr_rx_timeout_o <= 1'b0; intr_err_o <= 1'b0;
      end else begin
         if (pwrite_i) begin
            case (paddr_i)
               12'h000: baud  <= pwdata_i[BAUD_W-1:0];
               12'h00C: ctrl  <= pwdata_i[5:0];
               12'h014: ie    <= pwdata_i[3:0];
               12'h018: tx_wm <= pwdata_i[7:0];
               12'h01C: rx_wm <= pwdata_i[7:0];
               12'h020: rx_to <= pwdata_i[7:0];
               default: ;
            endcase
         end
         if (rd) begin
            case (paddr_i)
               12'h000: prdata_o <= 32'(baud);
               12'h008: prdata_o <= rx_empty ? '0 : 32'(rx_mem[rx_rp]);
               12'h00C: prdata_o <= 32'(ctrl);
               12'h010: prdata_o <= status;
               12'h014: prdata_o <= 32'(ie);
               12'h018: prdata_o <= 32'(tx_wm);
               12'h01C: prdata_o <= 32'(rx_wm);
               12'h020: prdata_o <= 32'(rx_to);
               default: prdata_o <= '0;
            endcase
         end
         // sticky: set beats write-1-to-clear
         rx_ovf  <= ovf_set    | (rx_ovf  & ~(wr_st & pwdata_i[5]));
         par_err <= par_set    | (par_err & ~(wr_st & pwdata_i[6]));
         frm_err <= frm_set    | (frm_err & ~(wr_st & pwdata_i[7]));
         tx_ovf  <= (wr_tx & tx_full) | (tx_ovf & ~(wr_st & pwdata_i[8]));

         if (tx_push) tx_wp <= tx_wp + AW'(1);
         if (tx_pop)  tx_rp <= tx_rp + AW'(1);
         if (rx_push) rx_wp <= rx_wp + AW'(1);
         if (rx_pop)  rx_rp <= rx_rp + AW'(1);
         tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
         rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);

         // TX datapath; the registered line delays the wire one cycle
         tx_st <= tx_nx;
         tx_q  <= t_line;
         if (tx_go) begin
            t_n      <= baud;
            t_par_en <= ctrl[2];
            t_stop2  <= ctrl[4];
            t_sh     <= tx_mem[tx_rp];
            t_par    <= ^tx_mem[tx_rp] ^ ctrl[3];
            t_cnt    <= '0;
            t_bit    <= '0;
         end else if (tx_st != S_IDLE) begin
            if (t_last) begin
               t_cnt <= '0;
               if (tx_st == S_DATA) begin
                  t_sh  <= t_sh >> 1;
                  t_bit <= t_bit + 4'd1;
               end
            end else t_cnt <= t_cnt + ONE_B;
         end

         // RX datapath; byte_v pushes one cycle after the stop sample
         s1     <= ctrl[5] ? tx_q : rx_i;
         s2     <= s1;
         s_prev <= s2;
         rx_st  <= rx_nx;
         byte_v <= 1'b0;
         if (r_go) begin
            r_n      <= baud;
            r_par_en <= ctrl[2];
            r_odd    <= ctrl[3];
            r_cnt    <= '0;
            r_bit    <= '0;
         end else if (rx_st != S_IDLE) begin
            if (r_samp) begin
               r_cnt <= '0;
               if (rx_st == S_DATA) begin
                  r_sh  <= {s2, r_sh[DATA_W-1:1]};
                  r_bit <= r_bit + 4'd1;
               end
               if (rx_st == S_STOP) byte_v <= s2;
            end else r_cnt <= r_cnt + ONE_N;
         end

         // RX timeout counts bit times of idle line with data waiting
         if (rx_pop || rx_push) begin
            to_div <= '0; to_cnt <= '0; to_flag <= 1'b0;
         end else begin
            if (!rx_empty && rx_st == S_IDLE) begin
               if (to_div == baud - ONE_N) begin
                  to_div <= '0;
                  if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
               end else to_div <= to_div + ONE_N;
            end
            if (rx_to != 8'd0 && to_cnt == rx_to) to_flag <= 1'b1;
         end

         intr_tx_o         <= ie[0] & (8'(tx_cnt) <= tx_wm);
         intr_rx_o         <= ie[1] & (8'(rx_cnt) >= rx_wm) & (rx_cnt != '0);
         intr_rx_timeout_o <= ie[2] & to_flag;
         intr_err_o        <= ie[3] & (rx_ovf | par_err | frm_err | tx_ovf);
      end
   end
endmodule

// File: doc/uart_core_v2.md
# uart_core_v2

Parametrised successor UART peripheral on the same register bus (pclk_i domain). Integrates TX/RX serialisers, depth-parametrised TX and RX FIFOs, and a configurable frame format: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits. Adds internal loopback, sticky error status, programmable watermarks and RX timeout, and masked interrupts. Sits between the bus decoder and the pad pair rx_i/tx_o.

## Interface
- DATA_W, 8: data bits per frame, 5..8.
- FIFO_DEPTH, 8: entries per FIFO, power of 2, 2..128.
- BAUD_W, 16: width of clocks-per-bit divisor.
- pclk_i input 1: clock, all logic on rising edge.
- prst_i input 1: reset, synchronous, active-high.
- paddr_i input 12: byte address.
- pwdata_i input 32: write data.
- pwrite_i input 1: write strobe, one access per cycle.
- pread_i input 1: read strobe; ignored when pwrite_i=1.
- prdata_o output 32: registered read data.
- rx_i input 1: serial in, asynchronous.
- tx_o output 1: serial out, idle high.
- intr_tx_o output 1: TX level interrupt.
- intr_rx_o output 1: RX level interrupt.
- intr_rx_timeout_o output 1: RX timeout interrupt.
- intr_err_o output 1: error interrupt.

## Operation
- Register map; unlisted addresses read 0, writes ignored:
  - 0x000 BAUD, RW, [BAUD_W-1:0]: clocks per bit N.
  - 0x004 TXDATA, W: push [DATA_W-1:0] into TX FIFO. Dropped when full; sets TX_OVF.
  - 0x008 RXDATA, R: pop RX FIFO and return byte. Returns 0 with no pop when empty.
  - 0x00C CTRL, RW: [0] tx_en, [1] rx_en, [2] par_en, [3] par_odd, [4] stop2, [5] loopback.
  - 0x010 STATUS, R: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy, [5] RX_OVF, [6] PAR_ERR, [7] FRM_ERR, [8] TX_OVF, [15:8] tx_count, [23:16] rx_count.
    - Bits [8:5] are sticky. Writing 1 to a sticky bit clears it.
    - When a set event and a clear hit the same cycle, set wins.
  - 0x014 IE, RW, [3:0]: enables for tx, rx, timeout, err.
  - 0x018 TX_WM, 0x01C RX_WM: 8-bit watermarks.
  - 0x020 RX_TO, 8 bits: timeout in bit times; 0 disables.
- Interrupts are registered levels:
  - intr_tx_o = IE[0] & (tx_count ≤ TX_WM).
  - intr_rx_o = IE[1] & (rx_count ≥ RX_WM) & (rx_count ≠ 0).
  - intr_rx_timeout_o = IE[2] & timeout_flag.
  - intr_err_o = IE[3] & |sticky.
- TX FSM: IDLE → START → DATA → (PARITY if par_en) → STOP → IDLE.
  - Leaves IDLE when tx_en=1, TX FIFO non-empty, and N ≥ 4. FIFO pop happens on that edge.
  - BAUD and CTRL format bits are latched at START; changes mid-frame apply to the next frame.
  - Data goes out LSB first. Parity is XOR of data bits, inverted when par_odd.
  - STOP lasts N or 2N cycles.
  - Back-to-back frames: START follows the last stop cycle with no idle gap.
  - Clearing tx_en mid-frame finishes the current frame.
- RX FSM: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - Input is rx_i, or tx_o when loopback=1, through a 2-flop synchroniser.
  - IDLE → START on a synchronised falling edge when rx_en=1 and N ≥ 4.
  - Start bit is checked at N/2 (integer division). If high, treated as a glitch → IDLE.
  - Later samples are spaced N cycles apart.
  - Only the first stop bit is checked. Stop=0 → FRM_ERR, byte discarded.
  - Parity mismatch → PAR_ERR, byte still stored.
  - Full RX FIFO → byte dropped, RX_OVF set.
- Loopback forces tx_o=1 externally; the frame is routed internally.
- Timeout counter:
  - Counts bit times while RX FIFO is non-empty and the RX FSM is IDLE.
  - Clears on a RXDATA pop or on a received byte.
  - timeout_flag sets when count == RX_TO (RX_TO ≠ 0) and holds until cleared.
- A FIFO push and pop in the same cycle both happen; the count is unchanged.

## Timing
- Reset values:
  - All registers, counts, sticky bits, prdata_o and interrupts are 0.
  - tx_o=1. FIFOs are empty. Both FSMs are IDLE.
- Reset mid-frame aborts the frame; tx_o=1 at the next edge.
- Register writes take effect at the edge ending the pwrite_i cycle.
- Read: prdata_o is valid on the cycle after pread_i and holds until the next read.
- RXDATA pop occurs at the pread_i edge. STATUS reflects the pop one cycle later.
- TX latency: TXDATA write at edge k → tx_o falls at edge k+2 when idle and enabled.
- Frame length: N·(1+DATA_W+par_en+1+stop2) cycles.
- RX byte enters the FIFO 1 cycle after the stop-bit sample. Synchroniser adds 2 cycles of input latency.
- Interrupt outputs lag their causes by 1 cycle.

## Test plan
- BAUD=16, CTRL=0x03, write TXDATA 0xA5 → tx_o low for 16 cycles, then 1,0,1,0,0,1,0,1, then stop high; total frame 160 cycles.
- Loopback, par_en, par_odd, stop2; send 0x3C → RXDATA reads 0x3C, STATUS[7:5]=0, frame 192 cycles.
- Push 9 bytes into FIFO_DEPTH=8 with tx_en=0 → tx_full=1, tx_count=8, TX_OVF=1, intr_err_o=1 once IE[3]=1. Write STATUS=0x100 → TX_OVF clears.
- External rx_i frame with stop bit 0 → FRM_ERR=1, rx_count stays 0. A 3-cycle low glitch on rx_i → no byte, no error.
- RX_TO=4, IE=0x4, receive 1 byte → intr_rx_timeout_o asserts after 4 idle bit times. Read RXDATA → deasserts next cycle.
- Assert prst_i mid-transmit → next cycle tx_o=1, all counts 0, and STATUS reads 0x0000_000A.
